gauss_win_seq: RTL and testbench
================================

Name: gauss_win_seq

Overview:
- Line sequencer that turns a raster pixel stream into 7-tap windows for the downstream 7-tap Gaussian filter (1,8,14,18,14,8,1).
- Windows use edge replication at both line ends, so it emits exactly one window per input pixel.
- Sits between the pixel source (valid/ready) and the filter's in_window_valid/in_window_value inputs.
- One line per start command; reports busy/done to the frame-level controller.

Parameters:
- DATA_WIDTH, 14, bits per pixel sample.
- LEN_W, 11, width of line_len (max line 2^LEN_W-1 pixels).

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse: begin a line of line_len pixels.
- line_len  input  LEN_W  pixels in line, sampled on accepted start.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse after last window of the line.
- in_valid  input  1  pixel source has data.
- in_data  input  DATA_WIDTH  pixel sample.
- in_ready  output  1  block accepts pixel this cycle.
- win_valid  output  1  window valid (drives filter in_window_valid).
- win_value  output  7*DATA_WIDTH  window; tap k at bits [DATA_WIDTH*k +: DATA_WIDTH], k=0..6.

Behaviour:
- Reset (rst=1 at edge): state IDLE, busy=0, done=0, in_ready=0, win_valid=0, win_value=0, counters cleared, stored samples discarded. Applies mid-line; no partial windows afterwards.
- Window definition: for pixel index i (0..N-1), tap k = x[clamp(i+k-3, 0, N-1)], N = latched line_len. Exactly N windows per line, in index order.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: in_ready=0. start=1 with line_len>0 latches N, goes to RUN, busy=1 next cycle. start with line_len=0 goes directly to DONE (no windows). start in any non-IDLE state is ignored.
- RUN: in_ready=1 until N pixels are accepted, then 0. Accept = in_valid & in_ready. First accepted pixel x0 fills taps 0..3 (left replication). Window i is emitted (win_valid=1, registered) on the cycle after accepting x[i+3], for i+3 <= N-1. in_valid gaps stall output; no window without a fresh accept in RUN. After accepting x[N-1], go to FLUSH.
- FLUSH: in_ready=0. Emits the remaining min(N,3) windows on consecutive cycles, with x[N-1] replicated into the right taps. The first flush window is on the cycle after the FLUSH entry edge, i.e. immediately following the window for x[N-1]'s accept. No gap. After the last window, go to DONE.
- DONE: done=1 for exactly one cycle, busy drops to 0 the same cycle, then IDLE. A new start is accepted the cycle after done.
- win_value=0 whenever win_valid=0. The downstream filter has no backpressure, so windows are never held.
- Internal index counters are LEN_W bits and never wrap for legal N.

Test Plan:
- N=8, pixels 10..17 back-to-back -> 8 windows on consecutive cycles. Window0 taps0..6 = 10,10,10,10,11,12,13; window7 = 14,15,16,17,17,17,17. First win_valid is the cycle after accepting 13. done is 1 cycle after window7; busy high for start+1 through done.
- N=1, pixel 5 -> one window, all taps 5, then done. N=2, pixels 3,9 -> windows 3,3,3,3,9,9,9 and 3,3,3,9,9,9,9.
- N=0 start -> done pulse on the next cycle, no win_valid, in_ready stays 0.
- N=6 with in_valid toggling 1,0,0,1,... -> same window contents as gapless. Window count 6; win_valid only on cycles after accepts plus 3 flush cycles. in_ready drops after the 6th accept and extra in_valid is ignored.
- start pulsed again during RUN with line_len=3 -> ignored; current line completes with the original N.
- rst asserted after the 4th pixel of an N=8 line -> next cycle all outputs 0, state IDLE. A new N=4 line with pixels 1..4 yields windows starting 1,1,1,1,2,3,4, with no stale data.

Source files
------------

// File: rtl/gauss_win_seq.sv
// gauss_win_seq: raster line sequencer producing 7-tap edge-replicated
// pixel windows, one per input pixel, for a downstream 7-tap filter.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start, line_len begin a line of line_len pixels (start ignored unless idle)
//   busy, done      line in progress / one-cycle end-of-line pulse
//   in_valid, in_data, in_ready   pixel input handshake
//   win_valid, win_value          window output, tap k at [DATA_WIDTH*k +: DATA_WIDTH]
module gauss_win_seq #(
    parameter int DATA_WIDTH = 14,
    parameter int LEN_W      = 11
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LEN_W-1:0]        line_len,
    output logic                    busy,
    output logic                    done,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    in_ready,
    output logic                    win_valid,
    output logic [7*DATA_WIDTH-1:0] win_value
);

    localparam int WW = 7 * DATA_WIDTH;
    localparam int HW = 6 * DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e             state_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   acc_cnt_q;
    logic [1:0]         fl_cnt_q;
    // Taps 1..6 of the most recent window position; the new sample (or the
    // replicated right-edge sample) is shifted in above them.
    logic [HW-1:0]      hist_q;
    logic [WW-1:0]      win_q;
    logic               win_valid_q;
    logic               busy_q;
    logic               done_q;
    logic               in_ready_q;

    logic                  accept;
    logic                  first_px;
    logic                  last_px;
    logic                  emit_run;
    logic [1:0]            fl_tot;
    logic [1:0]            fl_shift;
    logic [DATA_WIDTH-1:0] edge_px;
    logic [WW-1:0]         win_acc_d;
    logic [WW-1:0]         win_fl_d;

    always_comb begin
        accept   = in_valid & in_ready_q;
        first_px = (acc_cnt_q == '0);
        last_px  = (acc_cnt_q == len_q - LEN_W'(1));
        // Window i leaves on the accept of pixel i+3.
        emit_run = (acc_cnt_q >= LEN_W'(3));
        fl_tot   = (len_q > LEN_W'(2)) ? 2'd3 : len_q[1:0];
        edge_px  = hist_q[HW-1 -: DATA_WIDTH];

        // Lines shorter than 3 never emitted in RUN, so the first flush
        // window must skip the virtual positions that would have been
        // dropped; advance 4-N positions in one step instead of one.
        fl_shift = 2'd1;
        if (fl_cnt_q == 2'd0) begin
            if (len_q == LEN_W'(1)) begin
                fl_shift = 2'd3;
            end else if (len_q == LEN_W'(2)) begin
                fl_shift = 2'd2;
            end
        end

        // First pixel fills every tap: left-edge replication.
        if (first_px) begin
            win_acc_d = {7{in_data}};
        end else begin
            win_acc_d = {in_data, hist_q};
        end

        win_fl_d = {edge_px, hist_q};
        case (fl_shift)
            2'd2: win_fl_d = {edge_px, edge_px,
                              hist_q[HW-1:DATA_WIDTH]};
            2'd3: win_fl_d = {edge_px, edge_px, edge_px,
                              hist_q[HW-1:2*DATA_WIDTH]};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            acc_cnt_q   <= '0;
            fl_cnt_q    <= '0;
            hist_q      <= '0;
            win_q       <= '0;
            win_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            // Windows are never held: default to an empty output.
            win_valid_q <= 1'b0;
            win_q       <= '0;
            done_q      <= 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (line_len != '0) begin
                            len_q      <= line_len;
                            acc_cnt_q  <= '0;
                            fl_cnt_q   <= '0;
                            busy_q     <= 1'b1;
                            in_ready_q <= 1'b1;
                            state_q    <= S_RUN;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end

                S_RUN: begin
                    if (accept) begin
                        hist_q    <= win_acc_d[WW-1:DATA_WIDTH];
                        acc_cnt_q <= acc_cnt_q + LEN_W'(1);
                        if (emit_run) begin
                            win_valid_q <= 1'b1;
                            win_q       <= win_acc_d;
                        end
                        if (last_px) begin
                            in_ready_q <= 1'b0;
                            fl_cnt_q   <= '0;
                            state_q    <= S_FLUSH;
                        end
                    end
                end

                S_FLUSH: begin
                    // One extra cycle after the last window so that done
                    // follows the last window rather than coinciding.
                    if (fl_cnt_q == fl_tot) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        hist_q      <= win_fl_d[WW-1:DATA_WIDTH];
                        win_valid_q <= 1'b1;
                        win_q       <= win_fl_d;
                        fl_cnt_q    <= fl_cnt_q + 2'd1;
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign in_ready  = in_ready_q;
    assign win_valid = win_valid_q;
    assign win_value = win_q;

endmodule

// File: tb/tb_gauss_win_seq.sv
// tb_gauss_win_seq: randomized and directed bench for gauss_win_seq,
// checked every cycle against a clamp-index reference model.
module tb_gauss_win_seq;

    localparam int DW = 14;
    localparam int LW = 11;
    localparam int WW = 7 * DW;

    logic          clk;
    logic          rst;
    logic          start;
    logic [LW-1:0] line_len;
    logic          busy;
    logic          done;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          win_valid;
    logic [WW-1:0] win_value;

    gauss_win_seq #(.DATA_WIDTH(DW), .LEN_W(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .line_len  (line_len),
        .busy      (busy),
        .done      (done),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .win_valid (win_valid),
        .win_value (win_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%b expected=%b", nm, $time, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [WW-1:0] act,
                        input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", nm, $time, act, exp);
        end
    endtask

    function automatic logic [WW-1:0] pk(input int a0, input int a1,
        input int a2, input int a3, input int a4, input int a5, input int a6);
        int a[7];
        logic [WW-1:0] w;
        a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
        a[4] = a4; a[5] = a5; a[6] = a6;
        w = '0;
        for (int k = 0; k < 7; k++) w[DW*k +: DW] = a[k][DW-1:0];
        return w;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int            c;
        logic [WW-1:0] v;
    } ev_t;

    int            cyc = 0;
    int            m_mode = 0;   // 0 idle, 1 taking pixels, 2 finishing
    int            m_n = 0;
    int            m_acc = 0;
    int            m_done = -1;
    logic [DW-1:0] m_px [0:2047];
    ev_t           exp_q [$];

    function automatic logic [WW-1:0] mwin(input int i);
        logic [WW-1:0] w;
        int idx;
        w = '0;
        for (int k = 0; k < 7; k++) begin
            idx = i + k - 3;
            if (idx < 0) idx = 0;
            if (idx > m_n - 1) idx = m_n - 1;
            w[DW*k +: DW] = m_px[idx];
        end
        return w;
    endfunction

    always @(posedge clk) begin : mdl
        int c;
        int nf;
        ev_t e;
        c = cyc;
        if (rst) begin
            m_mode = 0;
            m_acc  = 0;
            m_done = -1;
            exp_q.delete();
        end else begin
            case (m_mode)
                0: if (start) begin
                    if (line_len != 0) begin
                        m_n = int'(line_len);
                        m_acc = 0;
                        m_mode = 1;
                    end else begin
                        m_mode = 2;
                        m_done = c + 1;
                    end
                end
                1: if (in_valid) begin
                    m_px[m_acc] = in_data;
                    if (m_acc >= 3) begin
                        e.c = c + 1;
                        e.v = mwin(m_acc - 3);
                        exp_q.push_back(e);
                    end
                    if (m_acc == m_n - 1) begin
                        nf = (m_n < 3) ? m_n : 3;
                        for (int f = 0; f < nf; f++) begin
                            e.c = c + 2 + f;
                            e.v = mwin(m_n - nf + f);
                            exp_q.push_back(e);
                        end
                        m_done = c + 2 + nf;
                        m_mode = 2;
                    end
                    m_acc++;
                end
                default: if (c == m_done) m_mode = 0;
            endcase
        end
        cyc = cyc + 1;
    end

    // ---------------- per-cycle compare ----------------
    bit            chk_en = 0;
    logic [WW-1:0] cap [$];
    int            first_win = -1;
    int            last_done = -1;

    always @(negedge clk) begin : cmp
        logic e_done;
        if (chk_en) begin
            e_done = (m_mode == 2) && (cyc == m_done);
            chk1("done", done, e_done);
            chk1("busy", busy, (m_mode != 0) && !e_done);
            chk1("in_ready", in_ready, m_mode == 1);
            if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
                chk1("win_valid", win_valid, 1'b1);
                chkw("win_value", win_value, exp_q[0].v);
                void'(exp_q.pop_front());
            end else begin
                chk1("win_valid_idle", win_valid, 1'b0);
                chkw("win_value_idle", win_value, '0);
            end
            if (win_valid === 1'b1) begin
                cap.push_back(win_value);
                if (first_win < 0) first_win = cyc;
            end
            if (done === 1'b1) last_done = cyc;
        end
    end

    // ---------------- stimulus ----------------
    logic [DW-1:0] line_px [0:63];
    int            s_cyc;

    task automatic run_line(input int n, input int gap, input bit restart);
        int t;
        cap.delete();
        first_win = -1;
        last_done = -1;
        @(posedge clk); #1;
        start = 1'b1;
        line_len = LW'(n);
        s_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        line_len = LW'($urandom);
        t = 0;
        while (m_mode != 0 && t < 3000) begin
            case (gap)
                0: in_valid = 1'b1;
                1: in_valid = (t % 3 == 0);
                default: in_valid = 1'($urandom);
            endcase
            if (m_mode == 1 && m_acc < 64) in_data = line_px[m_acc];
            else in_data = DW'($urandom);
            if (restart && t == 2) begin
                start = 1'b1;
                line_len = LW'(3);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            t++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        chk1("line_timeout", t >= 3000, 1'b0);
        chki("win_count", cap.size(), n);
    endtask

    initial begin
        int n;
        int t;
        rst = 1'b1;
        start = 1'b0;
        line_len = '0;
        in_valid = 1'b0;
        in_data = '0;
        @(posedge clk); #1;
        chk_en = 1;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b0);
        chkw("rst_win", win_value, '0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int k = 0; k < 8; k++) line_px[k] = DW'(10 + k);
        run_line(8, 0, 0);
        if (cap.size() == 8) begin
            chkw("n8_w0", cap[0], pk(10, 10, 10, 10, 11, 12, 13));
            chkw("n8_w7", cap[7], pk(14, 15, 16, 17, 17, 17, 17));
        end
        chki("n8_first_win", first_win, s_cyc + 5);
        chki("n8_done", last_done, s_cyc + 13);

        line_px[0] = DW'(5);
        run_line(1, 0, 0);
        if (cap.size() == 1) chkw("n1_w0", cap[0], pk(5, 5, 5, 5, 5, 5, 5));

        line_px[0] = DW'(3);
        line_px[1] = DW'(9);
        run_line(2, 0, 0);
        if (cap.size() == 2) begin
            chkw("n2_w0", cap[0], pk(3, 3, 3, 3, 9, 9, 9));
            chkw("n2_w1", cap[1], pk(3, 3, 3, 9, 9, 9, 9));
        end

        run_line(0, 0, 0);
        chki("n0_done", last_done, s_cyc + 1);

        for (int k = 0; k < 6; k++) line_px[k] = DW'(20 + k);
        run_line(6, 1, 0);
        if (cap.size() == 6) begin
            chkw("n6_w0", cap[0], pk(20, 20, 20, 20, 21, 22, 23));
            chkw("n6_w5", cap[5], pk(22, 23, 24, 25, 25, 25, 25));
        end

        for (int k = 0; k < 5; k++) line_px[k] = DW'(40 + k);
        run_line(5, 0, 1);

        // Reset in the middle of a line, after the fourth pixel.
        for (int k = 0; k < 8; k++) line_px[k] = DW'(100 + k);
        @(posedge clk); #1;
        start = 1'b1;
        line_len = LW'(8);
        @(posedge clk); #1;
        start = 1'b0;
        t = 0;
        while (m_acc < 4 && t < 100) begin
            in_valid = 1'b1;
            in_data = line_px[m_acc];
            @(posedge clk); #1;
            t++;
        end
        chk1("mid_timeout", t >= 100, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_done", done, 1'b0);
        chk1("mid_rst_ready", in_ready, 1'b0);
        chk1("mid_rst_wv", win_valid, 1'b0);
        chkw("mid_rst_win", win_value, '0);
        for (int k = 0; k < 4; k++) line_px[k] = DW'(1 + k);
        run_line(4, 0, 0);
        if (cap.size() == 4) chkw("post_rst_w0", cap[0], pk(1, 1, 1, 1, 2, 3, 4));

        for (int r = 0; r < 15; r++) begin
            n = $urandom_range(0, 40);
            for (int k = 0; k < 64; k++) line_px[k] = DW'($urandom);
            run_line(n, 2, r[0]);
        end

        repeat (3) @(posedge clk);
        #1;
        chki("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
